cfg_table_wr_arbiter: RTL and testbench

//  Shares the single write port of the config/state tables between NUM_REQ loaders.

---
 rtl/cfg_table_wr_arbiter_pkg.sv | 7 +
 rtl/cfg_table_wr_arbiter_rr_pick.sv | 18 +
 rtl/cfg_table_wr_arbiter.sv | 113 +++++++++++
 tb/tb_cfg_table_wr_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_table_wr_arbiter_pkg.sv
// cfg_table_wr_arbiter_pkg: shared table geometry and the write-port arbiter state encoding.
package cfg_table_wr_arbiter_pkg;
  localparam int dwidth_RFadd = 8;
  localparam int num_col = 1;
  localparam int SEL_W = num_col*2+1;
  typedef enum logic [1:0] {IDLE, GRANT, BURST, DONE} arb_state_t;
endpackage

// File: rtl/cfg_table_wr_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker; the first set request at or after ptr wins.
module rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         win_oh,
  output logic [$clog2(NUM_REQ)-1:0] win_idx
);
  localparam int IW = $clog2(NUM_REQ);
  // Scan from the farthest offset down so the nearest request after ptr is assigned last.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (req[(int'(ptr)+i)%NUM_REQ]) win_idx = IW'((int'(ptr)+i)%NUM_REQ);
    win_oh = |req ? NUM_REQ'(1) << win_idx : '0;
  end
endmodule

// File: rtl/cfg_table_wr_arbiter.sv
// cfg_table_wr_arbiter: round-robin burst arbiter for the shared config/state table write port.
// Locks the port to one loader per burst; a watchdog ends bursts that stall.
module cfg_table_wr_arbiter
  import cfg_table_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = dwidth_RFadd,
  parameter int SEL_W   = cfg_table_wr_arbiter_pkg::SEL_W,
  parameter int TIMEOUT = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_len_m1,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
  input  logic [NUM_REQ*ADDR_W-1:0] req_add,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [SEL_W-1:0]          tbl_wr_en,
  output logic [ADDR_W-1:0]         tbl_wr_add,
  output logic [DATA_W-1:0]         tbl_wr_data,
  output logic                      burst_done,
  output logic                      err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT+1);
  arb_state_t state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, win_idx;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, win_oh;
  logic [ADDR_W-1:0] len_q, len_d, beat_q, beat_d, wr_add_q, wr_add_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [SEL_W-1:0] wr_en_q, wr_en_d, sel;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic bad_q, bad_d, beat, tmo;
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (.req(req), .ptr(ptr_q), .win_oh(win_oh), .win_idx(win_idx));
  assign sel = req_sel[owner_q*SEL_W +: SEL_W];
  assign beat = state_q == BURST && req_valid[owner_q];
  assign tmo = state_q == BURST && !beat && wd_q == WW'(TIMEOUT-1);
  assign gnt = gnt_q;
  assign req_ready = state_q == BURST ? gnt_q : '0;
  assign burst_done = state_q == DONE;
  // A bad select is flagged with the write it suppressed; a timeout is flagged as it expires.
  assign err = bad_q | tmo;
  assign tbl_wr_en = wr_en_q;
  assign tbl_wr_add = wr_add_q;
  assign tbl_wr_data = wr_data_q;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    len_d = len_q;
    beat_d = beat_q;
    wd_d = wd_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = GRANT;
        owner_d = win_idx;
        gnt_d = win_oh;
      end
      GRANT: begin
        state_d = BURST;
        len_d = req_len_m1[owner_q*ADDR_W +: ADDR_W];
        beat_d = '0;
        wd_d = '0;
        ptr_d = owner_q == IW'(NUM_REQ-1) ? '0 : owner_q + 1'b1;
      end
      BURST: begin
        beat_d = beat ? beat_q + 1'b1 : beat_q;
        wd_d = beat ? '0 : wd_q + 1'b1;
        if ((beat && beat_q == len_q) || tmo) begin
          state_d = DONE;
          gnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_en_d = beat && $onehot(sel) ? sel : '0;
    wr_add_d = beat ? req_add[owner_q*ADDR_W +: ADDR_W] : wr_add_q;
    wr_data_d = beat ? req_data[owner_q*DATA_W +: DATA_W] : wr_data_q;
    bad_d = beat && !$onehot(sel);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      gnt_q <= '0;
      ptr_q <= '0;
      len_q <= '0;
      beat_q <= '0;
      wd_q <= '0;
      wr_en_q <= '0;
      wr_add_q <= '0;
      wr_data_q <= '0;
      bad_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
      len_q <= len_d;
      beat_q <= beat_d;
      wd_q <= wd_d;
      wr_en_q <= wr_en_d;
      wr_add_q <= wr_add_d;
      wr_data_q <= wr_data_d;
      bad_q <= bad_d;
    end
  end
endmodule

// File: tb/tb_cfg_table_wr_arbiter.sv
// tb_cfg_table_wr_arbiter: vector table, directed corner sequences and a random run
// checked against a burst-level reference model of the write-port arbiter.
module tb_cfg_table_wr_arbiter;
  import cfg_table_wr_arbiter_pkg::*;
  localparam int N = 2;
  localparam int DW = 64;
  localparam int AW = dwidth_RFadd;
  localparam int SW = cfg_table_wr_arbiter_pkg::SEL_W;
  localparam int TO = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req, req_valid, req_ready, gnt;
  logic [N*AW-1:0] req_len_m1, req_add;
  logic [N*SW-1:0] req_sel;
  logic [N*DW-1:0] req_data;
  logic [SW-1:0] tbl_wr_en;
  logic [AW-1:0] tbl_wr_add;
  logic [DW-1:0] tbl_wr_data;
  logic burst_done, err;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  cfg_table_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .SEL_W(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len_m1(req_len_m1), .req_valid(req_valid),
    .req_sel(req_sel), .req_add(req_add), .req_data(req_data), .req_ready(req_ready),
    .gnt(gnt), .tbl_wr_en(tbl_wr_en), .tbl_wr_add(tbl_wr_add), .tbl_wr_data(tbl_wr_data),
    .burst_done(burst_done), .err(err)
  );

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: owner index, whether the grant / ready window is open, beats taken, idle run.
  int m_own, m_ptr, m_len, m_cnt, m_idle;
  bit m_gnt, m_rdy, m_done, m_bad;
  logic [SW-1:0] m_en;
  logic [AW-1:0] m_add;
  logic [DW-1:0] m_data;
  // Observation logs of the DUT, compared afterwards against hand-derived constants.
  logic [N-1:0] gq[$];
  int err_log[$], done_log[$];
  int cyc, wr_cnt;
  logic [N-1:0] pg;

  task automatic model_reset();
    m_own = 0; m_ptr = 0; m_len = 0; m_cnt = 0; m_idle = 0;
    m_gnt = 0; m_rdy = 0; m_done = 0; m_bad = 0;
    m_en = '0; m_add = '0; m_data = '0;
  endtask

  task automatic drv(int i, logic r, logic v, logic [AW-1:0] len, logic [SW-1:0] s,
                     logic [AW-1:0] a, logic [DW-1:0] d);
    req[i] = r;
    req_valid[i] = v;
    req_len_m1[i*AW +: AW] = len;
    req_sel[i*SW +: SW] = s;
    req_add[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; req_valid = '0; req_len_m1 = '0; req_sel = '0; req_add = '0; req_data = '0;
    repeat (2) @(negedge clk);
    check("reset outputs", {gnt, req_ready, tbl_wr_en, tbl_wr_add, tbl_wr_data, burst_done, err}, '0);
    rst_n = 1'b1;
    model_reset();
    gq.delete(); err_log.delete(); done_log.delete();
    cyc = 0; wr_cnt = 0; pg = '0;
  endtask

  // One cycle: inputs already driven by the caller; compare, then advance the model past the edge.
  task automatic step(string name);
    logic [N-1:0] eg;
    logic [SW-1:0] s;
    bit beat, exp_err;
    #1;
    eg = m_gnt ? N'(1) << m_own : '0;
    exp_err = m_bad || (m_rdy && !req_valid[m_own] && m_idle == TO-1);
    check({name, " gnt"}, gnt, eg);
    check({name, " ready"}, req_ready, m_rdy ? eg : '0);
    check({name, " burst_done"}, burst_done, m_done);
    check({name, " err"}, err, exp_err);
    check({name, " wr_en"}, tbl_wr_en, m_en);
    if (m_en != '0) check({name, " wr_add/data"}, {tbl_wr_add, tbl_wr_data}, {m_add, m_data});
    if (gnt != '0 && pg == '0) gq.push_back(gnt);
    pg = gnt;
    if (err) err_log.push_back(cyc);
    if (burst_done) done_log.push_back(cyc);
    if (tbl_wr_en != '0) wr_cnt++;
    beat = m_rdy && req_valid[m_own];
    s = req_sel[m_own*SW +: SW];
    m_en = (beat && $countones(s) == 1) ? s : '0;
    m_bad = beat && $countones(s) != 1;
    if (beat) begin
      m_add = req_add[m_own*AW +: AW];
      m_data = req_data[m_own*DW +: DW];
    end
    if (m_done) m_done = 0;
    else if (m_rdy) begin
      if (beat) begin m_cnt++; m_idle = 0; end
      else m_idle++;
      if (m_cnt == m_len + 1 || m_idle == TO) begin m_rdy = 0; m_gnt = 0; m_done = 1; end
    end else if (m_gnt) begin
      m_len = int'(req_len_m1[m_own*AW +: AW]);
      m_cnt = 0; m_idle = 0; m_rdy = 1;
      m_ptr = (m_own + 1) % N;
    end else if (req != '0) begin
      for (int i = N-1; i >= 0; i--) if (req[(m_ptr+i)%N]) m_own = (m_ptr+i)%N;
      m_gnt = 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  typedef struct {
    logic r, v;
    logic [SW-1:0] sel;
    logic [AW-1:0] add;
    logic [7:0] dat;
    logic [N-1:0] g, rdy;
    logic [SW-1:0] en;
    logic [AW-1:0] oadd;
    logic [7:0] odat;
    logic done;
  } vec_t;
  vec_t tv[8];

  initial begin
    tv[0] = '{1, 0, 1, 0, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 0};
    tv[1] = '{1, 0, 1, 0, 8'h00, 2'b01, 2'b00, 0, 0, 8'h00, 0};
    tv[2] = '{0, 1, 1, 0, 8'hD0, 2'b01, 2'b01, 0, 0, 8'h00, 0};
    tv[3] = '{0, 1, 1, 1, 8'hD1, 2'b01, 2'b01, 1, 0, 8'hD0, 0};
    tv[4] = '{0, 1, 1, 2, 8'hD2, 2'b01, 2'b01, 1, 1, 8'hD1, 0};
    tv[5] = '{0, 1, 1, 3, 8'hD3, 2'b01, 2'b01, 1, 2, 8'hD2, 0};
    tv[6] = '{0, 0, 1, 0, 8'h00, 2'b00, 2'b00, 1, 3, 8'hD3, 1};
    tv[7] = '{0, 0, 1, 0, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 0};

    // Single requester, four-beat burst, explicit per-cycle vectors.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drv(0, tv[i].r, tv[i].v, 3, tv[i].sel, tv[i].add, DW'(tv[i].dat));
      #1;
      check($sformatf("t1[%0d] gnt", i), gnt, tv[i].g);
      check($sformatf("t1[%0d] ready", i), req_ready, tv[i].rdy);
      check($sformatf("t1[%0d] wr_en", i), tbl_wr_en, tv[i].en);
      check($sformatf("t1[%0d] done/err", i), {burst_done, err}, {tv[i].done, 1'b0});
      if (tv[i].en != '0)
        check($sformatf("t1[%0d] wr_add/data", i), {tbl_wr_add, tbl_wr_data}, {tv[i].oadd, DW'(tv[i].odat)});
      @(negedge clk);
    end

    // Both loaders request continuously: grants alternate 0,1,0,1.
    do_reset();
    drv(0, 1, 1, 1, 3'b010, 8'h20, 64'h1111);
    drv(1, 1, 1, 1, 3'b100, 8'h40, 64'h2222);
    for (int c = 0; c < 20; c++) step("t2");
    check("t2 grant count", gq.size() >= 4, 1);
    for (int k = 0; k < 4; k++)
      check($sformatf("t2 grant order %0d", k), k < gq.size() ? gq[k] : '0, k % 2 == 0 ? 2'b01 : 2'b10);

    // Owner 1 drops req after its first beat; lock holds and loader 0 waits.
    do_reset();
    begin
      int g10, r0;
      g10 = 0; r0 = 0;
      drv(0, 0, 0, 0, 3'b001, 8'h00, 64'h0);
      drv(1, 1, 1, 2, 3'b100, 8'h50, 64'hABCD);
      for (int c = 0; c < 10; c++) begin
        if (c == 3) begin
          drv(1, 0, 1, 2, 3'b100, 8'h51, 64'hABCE);
          drv(0, 1, 1, 0, 3'b001, 8'h60, 64'h5555);
        end
        if (c < 6) begin
          g10 += int'(gnt == 2'b10);
          r0 += int'(req_ready[0]);
        end
        step("t3");
      end
      check("t3 owner1 gnt cycles", g10, 4);
      check("t3 loader0 ready", r0, 0);
    end

    // Stalled owner: one beat of six, then silence until the watchdog fires.
    do_reset();
    drv(0, 1, 1, 5, 3'b001, 8'h70, 64'h7777);
    drv(1, 1, 1, 0, 3'b010, 8'h80, 64'h8888);
    for (int c = 0; c < 3; c++) step("t4");
    drv(0, 1, 0, 5, 3'b001, 8'h71, 64'h7778);
    for (int c = 3; c < 265; c++) step("t4");
    check("t4 err pulses", err_log.size(), 1);
    check("t4 err cycle", err_log.size() > 0 ? err_log[0] : -1, 258);
    check("t4 done cycle", done_log.size() > 0 ? done_log[0] : -1, 259);
    check("t4 next grant", gq.size() > 1 ? gq[1] : '0, 2'b10);

    // Multi-bit select on the second beat: write suppressed, err flagged, burst length unchanged.
    do_reset();
    drv(0, 1, 1, 3, 3'b001, 8'h90, 64'h9);
    for (int c = 0; c < 3; c++) step("t5");
    drv(0, 1, 1, 3, 3'b011, 8'h91, 64'hA);
    step("t5");
    drv(0, 0, 1, 3, 3'b001, 8'h92, 64'hB);
    for (int c = 4; c < 9; c++) step("t5");
    check("t5 err cycle", err_log.size() == 1 && err_log[0] == 4, 1);
    check("t5 done cycle", done_log.size() == 1 && done_log[0] == 6, 1);
    check("t5 writes", wr_cnt, 3);

    // Reset asserted mid-burst: outputs drop at once and the pointer restarts at loader 0.
    do_reset();
    drv(0, 1, 1, 3, 3'b001, 8'hA0, 64'hC);
    drv(1, 1, 1, 3, 3'b010, 8'hB0, 64'hD);
    for (int c = 0; c < 4; c++) step("t6");
    #2 rst_n = 1'b0;
    #1 check("t6 async reset", {gnt, req_ready, tbl_wr_en, burst_done, err}, '0);
    do_reset();
    drv(0, 1, 1, 0, 3'b001, 8'hA0, 64'hC);
    drv(1, 1, 1, 0, 3'b010, 8'hB0, 64'hD);
    for (int c = 0; c < 4; c++) step("t6");
    check("t6 first grant", gq.size() > 0 ? gq[0] : '0, 2'b01);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        logic [SW-1:0] s;
        s = $urandom_range(0, 7) == 0 ? SW'($urandom) : SW'(1) << $urandom_range(0, SW-1);
        drv(i, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, AW'($urandom_range(0, 3)),
            s, AW'($urandom), {$urandom, $urandom});
      end
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
